// File: rtl/set_assoc_cache_ctrl.sv
// set_assoc_cache_ctrl: 2-way set-associative read cache with 64-bit lines (two 32-bit words).
// Reads that hit complete in the same cycle. Read misses fetch the whole line over a
// req/done SRAM handshake. Writes always go through to SRAM; on a write hit the cached line
// is either invalidated (WRITE_POLICY=0) or updated in place (WRITE_POLICY=1).
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   i_mem_r_en, i_mem_w_en   pipeline read / write request (held while o_ready=0)
//   i_address, i_write_data  byte address and write word
//   i_flush                  invalidate all lines
//   o_read_data, o_ready     read word, pipeline stall control (0 = freeze)
//   o_hit                    IDLE read lookup hit
//   o_sram_*/i_sram_*        SRAM transaction request, address, data, completion pulse
//   o_hit_count/o_miss_count saturating read hit / miss statistics
module set_assoc_cache_ctrl #(
    parameter int unsigned SETS         = 64,
    parameter int unsigned WRITE_POLICY = 0,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_mem_r_en,
    input  logic             i_mem_w_en,
    input  logic [31:0]      i_address,
    input  logic [31:0]      i_write_data,
    input  logic             i_flush,
    output logic [31:0]      o_read_data,
    output logic             o_ready,
    output logic             o_hit,
    output logic             o_sram_req,
    output logic             o_sram_we,
    output logic [31:0]      o_sram_addr,
    output logic [31:0]      o_sram_wdata,
    input  logic [63:0]      i_sram_rdata,
    input  logic             i_sram_done,
    output logic [CNT_W-1:0] o_hit_count,
    output logic [CNT_W-1:0] o_miss_count
);
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 32 - IDX_W - 3;

    typedef enum logic [1:0] {StIdle, StFill, StWrite, StDone} state_t;

    state_t             r_state, w_state_next;
    logic [SETS-1:0]    r_valid [2];
    logic [SETS-1:0]    r_lru;  // way to evict next when both ways are valid
    logic [TAG_W-1:0]   r_tag   [2][SETS];
    logic [63:0]        r_data  [2][SETS];
    logic [31:2]        r_addr;
    logic [31:0]        r_wdata;
    logic               r_is_read;
    logic [31:0]        r_fill_word;
    logic [CNT_W-1:0]   r_hit_cnt, r_miss_cnt;

    logic [IDX_W-1:0]   w_idx, w_f_idx;
    logic [TAG_W-1:0]   w_tag, w_f_tag;
    logic [1:0]         w_hit_way;
    logic               w_lookup_hit, w_hit_w, w_victim;
    logic               w_rd_acc, w_wr_acc, w_accept, w_fill_we, w_wr_upd;
    logic [63:0]        w_hit_line;
    logic               w_unused;

    assign w_unused = ^i_address[1:0];

    // Lookup against the live request address
    assign w_idx = i_address[IDX_W+2:3];
    assign w_tag = i_address[31:IDX_W+3];
    always_comb begin
        for (int w = 0; w < 2; w++) begin
            w_hit_way[w] = r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag);
        end
    end
    assign w_lookup_hit = |w_hit_way;
    assign w_hit_w      = w_hit_way[1];
    assign w_hit_line   = r_data[w_hit_w][w_idx];

    // Fill target from the latched request
    assign w_f_idx  = r_addr[IDX_W+2:3];
    assign w_f_tag  = r_addr[31:IDX_W+3];
    assign w_victim = !r_valid[0][w_f_idx] ? 1'b0 :
                      !r_valid[1][w_f_idx] ? 1'b1 : r_lru[w_f_idx];

    // Read has priority when both enables are high
    assign w_rd_acc  = (r_state == StIdle) && i_mem_r_en;
    assign w_wr_acc  = (r_state == StIdle) && !i_mem_r_en && i_mem_w_en;
    assign w_accept  = (r_state == StIdle) && (w_state_next != StIdle);
    assign w_fill_we = (r_state == StFill) && i_sram_done;
    assign w_wr_upd  = (WRITE_POLICY != 0) && w_wr_acc && w_lookup_hit;

    assign o_hit        = w_rd_acc && w_lookup_hit;
    assign o_sram_req   = (r_state == StFill) || (r_state == StWrite);
    assign o_sram_we    = (r_state == StWrite);
    assign o_sram_addr  = (r_state == StFill)  ? {r_addr[31:3], 3'b000} :
                          (r_state == StWrite) ? {r_addr, 2'b00} : 32'h0;
    assign o_sram_wdata = (r_state == StWrite) ? r_wdata : 32'h0;
    assign o_hit_count  = r_hit_cnt;
    assign o_miss_count = r_miss_cnt;

    always_comb begin
        w_state_next = r_state;
        o_ready      = 1'b1;
        o_read_data  = 32'h0;
        unique case (r_state)
            StIdle: begin
                if (i_mem_r_en) begin
                    if (w_lookup_hit) begin
                        o_read_data = i_address[2] ? w_hit_line[63:32] : w_hit_line[31:0];
                    end else begin
                        o_ready      = 1'b0;
                        w_state_next = StFill;
                    end
                end else if (i_mem_w_en) begin
                    o_ready      = 1'b0;
                    w_state_next = StWrite;
                end
            end
            StFill, StWrite: begin
                o_ready = 1'b0;
                if (i_sram_done) w_state_next = StDone;
            end
            StDone: begin
                if (r_is_read) o_read_data = r_fill_word;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_valid[0]  <= '0;
            r_valid[1]  <= '0;
            r_lru       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_is_read   <= 1'b0;
            r_fill_word <= '0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_addr    <= i_address[31:2];
                r_wdata   <= i_write_data;
                r_is_read <= w_rd_acc;
            end
            if (w_rd_acc && w_lookup_hit && (r_hit_cnt != '1)) r_hit_cnt <= r_hit_cnt + 1'b1;
            if (w_rd_acc && !w_lookup_hit && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + 1'b1;
            if (i_flush) begin
                r_valid[0] <= '0;
                r_valid[1] <= '0;
                r_lru      <= '0;
            end else begin
                if (w_rd_acc && w_lookup_hit) r_lru[w_idx] <= ~w_hit_w;
                if (w_wr_acc && w_lookup_hit) begin
                    if (WRITE_POLICY == 0) r_valid[w_hit_w][w_idx] <= 1'b0;
                    else                   r_lru[w_idx] <= ~w_hit_w;
                end
            end
            // Placed after the flush so a coincident fill still installs its line
            if (w_fill_we) begin
                r_valid[w_victim][w_f_idx] <= 1'b1;
                r_lru[w_f_idx]             <= ~w_victim;
                r_fill_word <= r_addr[2] ? i_sram_rdata[63:32] : i_sram_rdata[31:0];
            end
        end
    end

    // Tag/data storage needs no reset: contents are qualified by r_valid
    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            r_tag[w_victim][w_f_idx]  <= w_f_tag;
            r_data[w_victim][w_f_idx] <= i_sram_rdata;
        end
        if (w_wr_upd) begin
            if (i_address[2]) r_data[w_hit_w][w_idx][63:32] <= i_write_data;
            else              r_data[w_hit_w][w_idx][31:0]  <= i_write_data;
        end
    end
endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Bench for set_assoc_cache_ctrl: instance 0 uses WRITE_POLICY=0 / CNT_W=16, instance 1 uses
// WRITE_POLICY=1 / CNT_W=4. Each instance is paired with a behavioural cache model (per-set
// line addresses, valid flags, LRU) and a sparse SRAM image.
module tb_set_assoc_cache_ctrl;
    localparam int SETS = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r_en   [2];
    logic        w_en   [2];
    logic        flush  [2];
    logic        sdone  [2];
    logic [31:0] addr   [2];
    logic [31:0] wdata  [2];
    logic [63:0] srdata [2];
    logic [31:0] rdata  [2];
    logic        ready  [2];
    logic        hit    [2];
    logic        sreq   [2];
    logic        swe    [2];
    logic [31:0] saddr  [2];
    logic [31:0] swd    [2];
    logic [15:0] hc0, mc0;
    logic [3:0]  hc1, mc1;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model
    bit          mv    [2][2][SETS];
    bit [28:0]   mline [2][2][SETS];
    bit [63:0]   mdat  [2][2][SETS];
    bit          mlru  [2][SETS];
    int          mhc   [2];
    int          mmc   [2];
    bit [31:0]   smem  [bit [32:0]];

    always #5 clk = ~clk;

    set_assoc_cache_ctrl #(.SETS(SETS), .WRITE_POLICY(0), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .i_mem_r_en(r_en[0]), .i_mem_w_en(w_en[0]),
        .i_address(addr[0]), .i_write_data(wdata[0]), .i_flush(flush[0]),
        .o_read_data(rdata[0]), .o_ready(ready[0]), .o_hit(hit[0]),
        .o_sram_req(sreq[0]), .o_sram_we(swe[0]), .o_sram_addr(saddr[0]),
        .o_sram_wdata(swd[0]), .i_sram_rdata(srdata[0]), .i_sram_done(sdone[0]),
        .o_hit_count(hc0), .o_miss_count(mc0));

    set_assoc_cache_ctrl #(.SETS(SETS), .WRITE_POLICY(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .i_mem_r_en(r_en[1]), .i_mem_w_en(w_en[1]),
        .i_address(addr[1]), .i_write_data(wdata[1]), .i_flush(flush[1]),
        .o_read_data(rdata[1]), .o_ready(ready[1]), .o_hit(hit[1]),
        .o_sram_req(sreq[1]), .o_sram_we(swe[1]), .o_sram_addr(saddr[1]),
        .o_sram_wdata(swd[1]), .i_sram_rdata(srdata[1]), .i_sram_done(sdone[1]),
        .o_hit_count(hc1), .o_miss_count(mc1));

    function automatic int get_hc(input int p);
        return (p == 0) ? int'(hc0) : int'(hc1);
    endfunction

    function automatic int get_mc(input int p);
        return (p == 0) ? int'(mc0) : int'(mc1);
    endfunction

    function automatic int cmax(input int p);
        return (p == 0) ? 65535 : 15;
    endfunction

    function automatic int set_of(input bit [31:0] a);
        return int'((a >> 3) % SETS);
    endfunction

    function automatic bit [32:0] skey(input int p, input bit [31:0] a);
        bit [32:0] k;
        k = {p[0], a[31:2], 2'b00};
        return k;
    endfunction

    function automatic bit [31:0] mem_rd(input int p, input bit [31:0] a);
        bit [32:0] k;
        bit [31:0] aw;
        k  = skey(p, a);
        aw = {a[31:2], 2'b00};
        if (smem.exists(k)) return smem[k];
        return aw * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction

    function automatic bit [31:0] wsel(input bit [63:0] l, input bit b);
        return b ? l[63:32] : l[31:0];
    endfunction

    function automatic int mlookup(input int p, input bit [31:0] a);
        int ix;
        ix = set_of(a);
        for (int w = 0; w < 2; w++)
            if (mv[p][w][ix] && (mline[p][w][ix] == a[31:3])) return w;
        return -1;
    endfunction

    function automatic int mvictim(input int p, input int ix);
        if (!mv[p][0][ix]) return 0;
        if (!mv[p][1][ix]) return 1;
        return int'(mlru[p][ix]);
    endfunction

    task automatic mflush(input int p);
        for (int ix = 0; ix < SETS; ix++) begin
            mv[p][0][ix] = 1'b0;
            mv[p][1][ix] = 1'b0;
            mlru[p][ix]  = 1'b0;
        end
    endtask

    task automatic mreset();
        for (int p = 0; p < 2; p++) begin
            mflush(p);
            mhc[p] = 0;
            mmc[p] = 0;
        end
    endtask

    // Serves one SRAM transaction of lat cycles with sram_req high, checking the request.
    task automatic sram_serve(input int p, input bit we, input bit [31:0] ea,
                              input bit [31:0] ewd, input bit [63:0] line, input int lat,
                              input int flush_at);
        for (int n = 1; n <= lat; n++) begin
            @(negedge clk);
            if (n == flush_at) flush[p] = 1'b1;
            if (n == lat) begin
                sdone[p]  = 1'b1;
                srdata[p] = line;
            end else begin
                srdata[p] = {$urandom, $urandom};
            end
            #1;
            n_cmp++;
            if ({sreq[p], swe[p], saddr[p], swd[p], ready[p], hit[p]} !==
                {1'b1, we, ea, ewd, 2'b00}) begin
                n_err++;
                $display("FAIL sram_handshake p=%0d cyc=%0d got req=%b we=%b addr=%h wd=%h rdy=%b hit=%b exp we=%b addr=%h wd=%h",
                         p, n, sreq[p], swe[p], saddr[p], swd[p], ready[p], hit[p], we, ea, ewd);
            end
            @(posedge clk);
            #1;
            flush[p] = 1'b0;
            sdone[p] = 1'b0;
        end
    endtask

    task automatic do_read(input int p, input bit [31:0] a, input int lat, input int flush_at);
        int        w, ix, vic;
        bit [63:0] line;
        ix = set_of(a);
        @(negedge clk);
        r_en[p] = 1'b1;
        addr[p] = a;
        #1;
        w = mlookup(p, a);
        n_cmp++;
        if (w >= 0) begin
            if ({ready[p], hit[p], rdata[p]} !== {2'b11, wsel(mdat[p][w][ix], a[2])}) begin
                n_err++;
                $display("FAIL read_hit p=%0d a=%h got rdy=%b hit=%b data=%h exp data=%h",
                         p, a, ready[p], hit[p], rdata[p], wsel(mdat[p][w][ix], a[2]));
            end
            mlru[p][ix] = (w == 0);
            if (mhc[p] < cmax(p)) mhc[p]++;
            @(posedge clk);
            #1;
            r_en[p] = 1'b0;
        end else begin
            if ({ready[p], hit[p]} !== 2'b00) begin
                n_err++;
                $display("FAIL read_miss_stall p=%0d a=%h got rdy=%b hit=%b exp 0 0",
                         p, a, ready[p], hit[p]);
            end
            if (mmc[p] < cmax(p)) mmc[p]++;
            @(posedge clk);
            line = {mem_rd(p, {a[31:3], 3'b100}), mem_rd(p, {a[31:3], 3'b000})};
            sram_serve(p, 1'b0, {a[31:3], 3'b000}, 32'h0, line, lat, flush_at);
            if (flush_at > 0 && flush_at < lat) mflush(p);
            vic = mvictim(p, ix);
            if (flush_at == lat) mflush(p);
            mv[p][vic][ix]    = 1'b1;
            mline[p][vic][ix] = a[31:3];
            mdat[p][vic][ix]  = line;
            mlru[p][ix]       = (vic == 0);
            @(negedge clk);
            #1;
            n_cmp++;
            if ({ready[p], hit[p], sreq[p], rdata[p]} !== {3'b100, wsel(line, a[2])}) begin
                n_err++;
                $display("FAIL read_done p=%0d a=%h got rdy=%b hit=%b req=%b data=%h exp data=%h",
                         p, a, ready[p], hit[p], sreq[p], rdata[p], wsel(line, a[2]));
            end
            @(posedge clk);
            #1;
            r_en[p] = 1'b0;
        end
    endtask

    task automatic do_write(input int p, input bit [31:0] a, input bit [31:0] d, input int lat);
        int w, ix;
        ix = set_of(a);
        @(negedge clk);
        w_en[p]  = 1'b1;
        addr[p]  = a;
        wdata[p] = d;
        #1;
        n_cmp++;
        if (ready[p] !== 1'b0) begin
            n_err++;
            $display("FAIL write_stall p=%0d a=%h got rdy=%b exp 0", p, a, ready[p]);
        end
        w = mlookup(p, a);
        if (w >= 0) begin
            if (p == 0) begin
                mv[p][w][ix] = 1'b0;
            end else begin
                if (a[2]) mdat[p][w][ix][63:32] = d;
                else      mdat[p][w][ix][31:0]  = d;
                mlru[p][ix] = (w == 0);
            end
        end
        @(posedge clk);
        sram_serve(p, 1'b1, {a[31:2], 2'b00}, d, 64'h0, lat, 0);
        smem[skey(p, a)] = d;
        @(negedge clk);
        #1;
        n_cmp++;
        if ({ready[p], sreq[p]} !== 2'b10) begin
            n_err++;
            $display("FAIL write_done p=%0d a=%h got rdy=%b req=%b exp 1 0", p, a, ready[p], sreq[p]);
        end
        @(posedge clk);
        #1;
        w_en[p] = 1'b0;
    endtask

    task automatic do_flush(input int p);
        @(negedge clk);
        flush[p] = 1'b1;
        @(posedge clk);
        #1;
        flush[p] = 1'b0;
        mflush(p);
    endtask

    task automatic test_counters(input int p);
        @(negedge clk);
        #1;
        n_cmp++;
        if (get_hc(p) !== mhc[p] || get_mc(p) !== mmc[p]) begin
            n_err++;
            $display("FAIL counters p=%0d got hit=%0d miss=%0d exp hit=%0d miss=%0d",
                     p, get_hc(p), get_mc(p), mhc[p], mmc[p]);
        end
    endtask

    task automatic test_reset();
        for (int p = 0; p < 2; p++) begin
            r_en[p] = 0; w_en[p] = 0; flush[p] = 0; sdone[p] = 0;
            addr[p] = 0; wdata[p] = 0; srdata[p] = 0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mreset();
        #1;
        for (int p = 0; p < 2; p++) begin
            n_cmp++;
            if ({ready[p], hit[p], rdata[p], sreq[p], swe[p], saddr[p], swd[p]} !==
                {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
                n_err++;
                $display("FAIL reset_outputs p=%0d got rdy=%b hit=%b data=%h req=%b we=%b addr=%h wd=%h",
                         p, ready[p], hit[p], rdata[p], sreq[p], swe[p], saddr[p], swd[p]);
            end
            test_counters(p);
        end
        // A stray done pulse while idle must be ignored
        @(negedge clk);
        sdone[0] = 1'b1;
        @(posedge clk);
        #1;
        sdone[0] = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if ({ready[0], sreq[0], rdata[0]} !== {2'b10, 32'h0}) begin
            n_err++;
            $display("FAIL idle_done_ignored got rdy=%b req=%b data=%h", ready[0], sreq[0], rdata[0]);
        end
    endtask

    task automatic test_read_miss_hit();
        smem[skey(0, 32'h100)] = 32'h1111_1111;
        smem[skey(0, 32'h104)] = 32'h2222_2222;
        do_read(0, 32'h104, 3, 0);
        do_read(0, 32'h104, 3, 0);
        do_read(0, 32'h100, 3, 0);
        test_counters(0);
    endtask

    task automatic test_lru();
        do_read(0, 32'h300, 2, 0);
        do_read(0, 32'h100, 2, 0);
        do_read(0, 32'h504, 1, 0);
        do_read(0, 32'h100, 2, 0);
        do_read(0, 32'h300, 4, 0);
        do_read(0, 32'h504, 2, 0);
        test_counters(0);
    endtask

    task automatic test_write_policy();
        smem[skey(0, 32'h100)] = 32'h1111_1111;
        smem[skey(1, 32'h100)] = 32'h1111_1111;
        for (int p = 0; p < 2; p++) begin
            do_read(p, 32'h100, 2, 0);
            do_write(p, 32'h100, 32'hDEAD_BEEF, 3);
            do_read(p, 32'h100, 2, 0);
            do_write(p, 32'h7654_3210, 32'h0BAD_F00D, 1);
            do_read(p, 32'h7654_3210, 2, 0);
            test_counters(p);
        end
    endtask

    task automatic test_flush();
        do_read(0, 32'h200, 2, 0);
        do_read(0, 32'h100, 3, 1);
        do_read(0, 32'h100, 2, 0);
        do_read(0, 32'h200, 2, 0);
        do_read(0, 32'h310, 2, 2);
        do_read(0, 32'h310, 2, 0);
        do_read(0, 32'h200, 2, 0);
        do_flush(0);
        do_read(0, 32'h200, 1, 0);
        do_read(0, 32'h310, 1, 0);
        do_read(0, 32'h104, 1, 0);
        test_counters(0);
    endtask

    task automatic test_reset_mid();
        do_read(0, 32'h100, 2, 0);
        @(negedge clk);
        r_en[0] = 1'b1;
        addr[0] = 32'h7000_0400;
        @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (sreq[0] !== 1'b1) begin
            n_err++;
            $display("FAIL fill_started got req=%b exp 1", sreq[0]);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({sreq[0], hc0, mc0} !== {1'b0, 16'h0, 16'h0}) begin
            n_err++;
            $display("FAIL reset_abort got req=%b hit_cnt=%0d miss_cnt=%0d exp 0 0 0",
                     sreq[0], hc0, mc0);
        end
        r_en[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mreset();
        do_read(0, 32'h7000_0400, 2, 0);
        do_read(0, 32'h100, 2, 0);
        test_counters(0);
    endtask

    task automatic test_saturation();
        do_read(1, 32'h208, 2, 0);
        for (int i = 0; i < 20; i++) do_read(1, 32'h20C, 1, 0);
        test_counters(1);
        n_cmp++;
        if (hc1 !== 4'hF) begin
            n_err++;
            $display("FAIL hit_saturate got %0d exp 15", hc1);
        end
    endtask

    task automatic test_random();
        bit [31:0] a;
        int        op, lat, fa;
        int        idxs [3] = '{0, 1, 32};
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 150; i++) begin
                a   = ($urandom_range(0, 3) << (3 + 6)) | (idxs[$urandom_range(0, 2)] << 3) |
                      ($urandom_range(0, 1) << 2) | $urandom_range(0, 3);
                op  = $urandom_range(0, 19);
                lat = $urandom_range(1, 4);
                fa  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, lat) : 0;
                if (op < 12)      do_read(p, a, lat, fa);
                else if (op < 19) do_write(p, a, $urandom, lat);
                else              do_flush(p);
            end
            test_counters(p);
        end
    endtask

    initial begin
        test_reset();
        test_read_miss_hit();
        test_lru();
        test_write_policy();
        test_flush();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout after %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end
endmodule
